ras_event_seq: RTL and testbench
================================

// Module: ras_event_seq
// PURPOSE
// - Frontend stage directly upstream of the return address stack (RAS).
// - Takes per-slot call/return predecode from a fetch bundle and computes return addresses.
// - Queues the resulting events and issues at most one push/pop per cycle to the RAS.
// - Multi-call/return bundles are serialised in program order, with backpressure to fetch.
// PARAMETERS
// - INSTR_PER_FETCH  2  instruction slots per fetch bundle; slot 0 is oldest.
// - QUEUE_DEPTH      4  event queue entries; power of 2, >= INSTR_PER_FETCH.
// PORTS
// - clk_i          in   1                          clock
// - rst_ni         in   1                          async reset, active low
// - flush_i        in   1                          drop all queued events
// - fetch_valid_i  in   1                          bundle valid
// - fetch_ready_o  out  1                          bundle accepted when valid & ready
// - is_call_i      in   INSTR_PER_FETCH            slot is call (jal/jalr, rd=x1/x5)
// - is_return_i    in   INSTR_PER_FETCH            slot is return (jalr, rs1=x1/x5)
// - rvc_i          in   INSTR_PER_FETCH            slot is compressed
// - pc_i           in   INSTR_PER_FETCH x riscv::VLEN   slot PC
// - ras_push_o     out  1                          push to RAS
// - ras_pop_o      out  1                          pop from RAS
// - ras_data_o     out  riscv::VLEN                return address for push
// - occupancy_o    out  $clog2(QUEUE_DEPTH)+1      queued event count
// BEHAVIOUR
// - Reset is asynchronous and active low.
//   - Reset state: queue empty, occupancy_o=0, ras_push_o=0, ras_pop_o=0, ras_data_o=0.
// - Event per slot i:
//   - call only   -> PUSH
//   - return only -> POP
//   - both set    -> POPPUSH (push_o=pop_o=1)
//   - neither     -> no event
// - Return address: ra = pc_i[i] + (rvc_i[i] ? 2 : 4), truncated to VLEN (wraps at 2^VLEN).
//   - POP-only entries store ra=0.
// - Enqueue:
//   - n = number of events in the bundle; free = QUEUE_DEPTH - occupancy + (dequeue this cycle).
//   - fetch_ready_o = !flush_i & (n <= free). Combinational from inputs and state.
//   - A bundle with n=0 is always ready unless flush_i.
//   - On valid & ready, the n events are written in slot order at the tail.
//   - No partial acceptance.
// - Dequeue:
//   - Outputs are driven from the head entry (registered state). Latency enqueue->output is 1 cycle.
//   - If non-empty and !flush_i, the head is consumed every cycle; the RAS never stalls.
//   - If empty: push_o=pop_o=0, data_o holds 0.
// - Simultaneous enqueue and dequeue in one cycle is allowed.
//   - occupancy' = occupancy + n - 1.
//   - The full queue is usable.
// - Pointers wrap modulo QUEUE_DEPTH. occupancy never exceeds QUEUE_DEPTH.
// - flush_i has priority over everything.
//   - In the flush cycle: push_o=pop_o=0, ready=0, nothing is enqueued.
//   - Next cycle: queue empty.
// - Inputs are ignored when fetch_valid_i=0.
// TESTING
// - Call at slot0, pc=0x8000_0000, rvc=0:
//   - next cycle push_o=1, data_o=0x8000_0004; then idle, occupancy 0.
// - Bundle with slot0 call (pc=0x100, rvc=1) and slot1 return:
//   - cycle+1: push_o=1, data_o=0x102.
//   - cycle+2: pop_o=1.
// - Slot with both call and return, pc=0x200:
//   - single cycle push_o=pop_o=1, data_o=0x204.
// - DEPTH=4: back-to-back 2-call bundles.
//   - Occupancy reaches 4 and ready drops only when free<2.
//   - Accepts again once free>=2; no event is lost or reordered.
// - Flush with 3 queued events:
//   - In the flush cycle push/pop=0 and ready=0.
//   - Next cycle occupancy=0; a later call is issued normally.
// - pc=2^VLEN-4 call, rvc=0 -> data_o=0 (wrap).
// - Async reset asserted mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/ras_event_seq.sv
// -----------------------------------------------------------------------------
// ras_event_seq
//
// Frontend stage sitting directly in front of the return address stack (RAS).
// Each fetch bundle carries per-slot call/return predecode. Every slot that is
// a call, a return, or both becomes one event; the events of an accepted bundle
// are written in slot (program) order into a small circular queue, and the
// queue head is issued to the RAS at a rate of one event per cycle. Fetch is
// back-pressured whenever a bundle's events would not fit. A bundle is either
// accepted whole or not at all.
//
// Event encoding per slot:
//   call only   -> push, address = return address
//   return only -> pop,  address = 0
//   call+return -> push and pop in the same cycle (coroutine swap)
//
// Return address = pc + (rvc ? 2 : 4), wrapping at 2^VLEN.
//
// Ports
//   clk_i          in   clock
//   rst_ni         in   asynchronous reset, active low
//   flush_i        in   discard all queued events; blocks fetch and the RAS
//   fetch_valid_i  in   fetch bundle valid
//   fetch_ready_o  out  bundle accepted when fetch_valid_i & fetch_ready_o
//   is_call_i      in   per-slot call flag (slot 0 is oldest)
//   is_return_i    in   per-slot return flag
//   rvc_i          in   per-slot compressed-instruction flag
//   pc_i           in   per-slot PC
//   ras_push_o     out  push ras_data_o onto the RAS
//   ras_pop_o      out  pop the RAS
//   ras_data_o     out  return address for the push (0 when idle)
//   occupancy_o    out  number of queued events
// -----------------------------------------------------------------------------
module ras_event_seq #(
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned QUEUE_DEPTH     = 4,   // power of 2, >= INSTR_PER_FETCH
   parameter int unsigned VLEN            = 64
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic                                   fetch_valid_i,
   output logic                                   fetch_ready_o,
   input  logic [INSTR_PER_FETCH-1:0]             is_call_i,
   input  logic [INSTR_PER_FETCH-1:0]             is_return_i,
   input  logic [INSTR_PER_FETCH-1:0]             rvc_i,
   input  logic [INSTR_PER_FETCH-1:0][VLEN-1:0]   pc_i,
   output logic                                   ras_push_o,
   output logic                                   ras_pop_o,
   output logic [VLEN-1:0]                        ras_data_o,
   output logic [$clog2(QUEUE_DEPTH):0]           occupancy_o
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Bit 1 = return, bit 0 = call, so the kind is just the two predecode bits.
   typedef enum logic [1:0] {
      EV_NONE    = 2'b00,
      EV_PUSH    = 2'b01,
      EV_POP     = 2'b10,
      EV_POPPUSH = 2'b11
   } ev_kind_e;

   typedef struct packed {
      logic            push;
      logic            pop;
      logic [VLEN-1:0] addr;
   } entry_t;

   // ---------------------------------------------------------------------------
   // Storage and pointers
   // ---------------------------------------------------------------------------
   entry_t           mem [QUEUE_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   // ---------------------------------------------------------------------------
   // Per-slot decode
   // ---------------------------------------------------------------------------
   ev_kind_e                   slot_kind  [INSTR_PER_FETCH];
   entry_t                     slot_entry [INSTR_PER_FETCH];
   logic [PTR_W-1:0]           slot_off   [INSTR_PER_FETCH];
   logic [INSTR_PER_FETCH-1:0] slot_ev;
   logic [CNT_W-1:0]           n_events;

   // NOTE: n_events is a running sum inside one always_comb, so it uses blocking
   // assignments and is given a default before the loop; every other output of
   // this block is assigned on every pass, so no latch can be inferred.
   always_comb begin
      n_events = '0;
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         slot_kind[i]        = ev_kind_e'({is_return_i[i], is_call_i[i]});
         slot_ev[i]          = (slot_kind[i] != EV_NONE);
         // Position of this slot's event among the bundle's events, so older
         // slots always land nearer the head.
         slot_off[i]         = n_events[PTR_W-1:0];
         slot_entry[i].push  = (slot_kind[i] == EV_PUSH) || (slot_kind[i] == EV_POPPUSH);
         slot_entry[i].pop   = (slot_kind[i] == EV_POP)  || (slot_kind[i] == EV_POPPUSH);
         // Pop-only events carry no address; zero keeps the RAS data bus quiet.
         slot_entry[i].addr  = slot_entry[i].push
                             ? pc_i[i] + (rvc_i[i] ? VLEN'(2) : VLEN'(4))
                             : '0;
         if (slot_ev[i]) begin
            n_events = n_events + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic             deq;
   logic             enq;
   logic [CNT_W-1:0] free_slots;

   // The RAS never stalls, so a non-empty head always leaves this cycle unless
   // a flush is discarding it.
   assign deq = (count != '0) && !flush_i;

   // Counting the departing head as free lets a full queue keep streaming.
   assign free_slots    = CNT_W'(QUEUE_DEPTH) - count + CNT_W'(deq);
   assign fetch_ready_o = !flush_i && (n_events <= free_slots);
   assign enq           = fetch_valid_i && fetch_ready_o;

   // ---------------------------------------------------------------------------
   // Pointer / count state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         if (enq) begin
            // Truncation is the modulo-depth wrap (depth is a power of two).
            tail <= tail + n_events[PTR_W-1:0];
         end
         count <= count + (enq ? n_events : '0) - CNT_W'(deq);
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------------
   // NOTE: the entries are deliberately not reset. An entry is only ever seen on
   // the outputs when count says it is live, and count is reset, so clearing
   // the array would only cost reset fan-out.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            if (slot_ev[i]) begin
               mem[tail + slot_off[i]] <= slot_entry[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // RAS side: head entry, gated so idle, flush and reset all read as zero.
   // ---------------------------------------------------------------------------
   assign ras_push_o  = deq && mem[head].push;
   assign ras_pop_o   = deq && mem[head].pop;
   assign ras_data_o  = deq ? mem[head].addr : '0;
   assign occupancy_o = count;

endmodule

// File: tb/tb_ras_event_seq.sv
// -----------------------------------------------------------------------------
// tb_ras_event_seq
//
// Bench for ras_event_seq. A scoreboard queue holds the events the bench
// expects the DUT to hold: entries are pushed when a bundle the bench expects
// to be accepted is driven, and popped when the DUT should be issuing the head.
// Scenario tasks add targeted cycle-exact checks on top of that.
// -----------------------------------------------------------------------------
module tb_ras_event_seq;

   localparam int VLEN  = 64;
   localparam int DEPTH = 4;
   localparam int IPF   = 2;

   typedef struct {
      logic            push;
      logic            pop;
      logic [VLEN-1:0] data;
   } exp_t;

   logic                       clk_i         = 1'b0;
   logic                       rst_ni        = 1'b0;
   logic                       flush_i       = 1'b0;
   logic                       fetch_valid_i = 1'b0;
   logic                       fetch_ready_o;
   logic [IPF-1:0]             is_call_i     = '0;
   logic [IPF-1:0]             is_return_i   = '0;
   logic [IPF-1:0]             rvc_i         = '0;
   logic [IPF-1:0][VLEN-1:0]   pc_i          = '0;
   logic                       ras_push_o;
   logic                       ras_pop_o;
   logic [VLEN-1:0]            ras_data_o;
   logic [2:0]                 occupancy_o;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   ras_event_seq #(
      .INSTR_PER_FETCH (IPF),
      .QUEUE_DEPTH     (DEPTH),
      .VLEN            (VLEN)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_ready_o (fetch_ready_o),
      .is_call_i     (is_call_i),
      .is_return_i   (is_return_i),
      .rvc_i         (rvc_i),
      .pc_i          (pc_i),
      .ras_push_o    (ras_push_o),
      .ras_pop_o     (ras_pop_o),
      .ras_data_o    (ras_data_o),
      .occupancy_o   (occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One cycle: drive at the negedge, compare just after, advance the scoreboard
   // at the posedge, return at the following negedge.
   task automatic drive_cycle(input logic            valid,
                              input logic [IPF-1:0]  call,
                              input logic [IPF-1:0]  ret,
                              input logic [IPF-1:0]  rvc,
                              input logic [VLEN-1:0] pc0,
                              input logic [VLEN-1:0] pc1,
                              input logic            flush,
                              output logic           accepted);
      logic [VLEN-1:0] pcs [IPF];
      int              n;
      int              occ;
      logic            deq;
      logic            exp_ready;
      exp_t            head;
      pcs[0] = pc0;
      pcs[1] = pc1;
      fetch_valid_i = valid;
      is_call_i     = call;
      is_return_i   = ret;
      rvc_i         = rvc;
      pc_i[0]       = pc0;
      pc_i[1]       = pc1;
      flush_i       = flush;
      #1;
      n = 0;
      for (int i = 0; i < IPF; i++) if (call[i] || ret[i]) n++;
      occ       = sb.size();
      deq       = (occ != 0) && !flush;
      exp_ready = !flush && (n <= DEPTH - occ + int'(deq));
      if (deq) head = sb[0];
      else     head = '{push: 1'b0, pop: 1'b0, data: '0};

      n_checks++;
      if (fetch_ready_o !== exp_ready)
         $display("FAIL ready: got %b expected %b (occ %0d n %0d flush %b)",
                  fetch_ready_o, exp_ready, occ, n, flush);
      else n_pass++;
      n_checks++;
      if (occupancy_o !== 3'(occ))
         $display("FAIL occupancy: got %0d expected %0d", occupancy_o, occ);
      else n_pass++;
      n_checks++;
      if (ras_push_o !== head.push)
         $display("FAIL push: got %b expected %b", ras_push_o, head.push);
      else n_pass++;
      n_checks++;
      if (ras_pop_o !== head.pop)
         $display("FAIL pop: got %b expected %b", ras_pop_o, head.pop);
      else n_pass++;
      if (deq || occ == 0) begin
         n_checks++;
         if (ras_data_o !== head.data)
            $display("FAIL data: got %h expected %h", ras_data_o, head.data);
         else n_pass++;
      end

      @(posedge clk_i);
      if (flush) begin
         sb.delete();
      end else begin
         if (deq) void'(sb.pop_front());
         if (valid && exp_ready) begin
            for (int i = 0; i < IPF; i++) begin
               if (call[i] || ret[i])
                  sb.push_back('{push: call[i], pop: ret[i],
                                 data: call[i] ? pcs[i] + (rvc[i] ? 64'd2 : 64'd4) : '0});
            end
         end
      end
      accepted = valid && exp_ready;
      @(negedge clk_i);
   endtask

   task automatic idle_cycle();
      logic acc;
      drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b0, acc);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         idle_cycle();
         guard++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d events still expected after %0d cycles", sb.size(), guard);
      end
      idle_cycle();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_i);
      #1;
      n_checks++;
      if (ras_push_o !== 1'b0) $display("FAIL reset_push: got %b expected 0", ras_push_o); else n_pass++;
      n_checks++;
      if (ras_pop_o !== 1'b0) $display("FAIL reset_pop: got %b expected 0", ras_pop_o); else n_pass++;
      n_checks++;
      if (ras_data_o !== '0) $display("FAIL reset_data: got %h expected 0", ras_data_o); else n_pass++;
      n_checks++;
      if (occupancy_o !== 3'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy_o); else n_pass++;
      n_checks++;
      if (fetch_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", fetch_ready_o); else n_pass++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_single_call();
      logic acc;
      drive_cycle(1'b1, 2'b01, 2'b00, 2'b00, 64'h8000_0000, '0, 1'b0, acc);
      idle_cycle();   // scoreboard expects push with 0x8000_0004 here
      #1;
      n_checks++;
      if (occupancy_o !== 3'd0) $display("FAIL call_idle_occupancy: got %0d expected 0", occupancy_o); else n_pass++;
      n_checks++;
      if (ras_push_o !== 1'b0) $display("FAIL call_idle_push: got %b expected 0", ras_push_o); else n_pass++;
   endtask

   task automatic test_call_return();
      logic acc;
      drive_cycle(1'b1, 2'b01, 2'b10, 2'b01, 64'h100, 64'h102, 1'b0, acc);
      idle_cycle();   // push 0x102
      #1;
      n_checks++;
      if (ras_pop_o !== 1'b1) $display("FAIL callret_second_pop: got %b expected 1", ras_pop_o); else n_pass++;
      n_checks++;
      if (ras_push_o !== 1'b0) $display("FAIL callret_second_push: got %b expected 0", ras_push_o); else n_pass++;
      drain();
   endtask

   task automatic test_poppush();
      logic acc;
      drive_cycle(1'b1, 2'b01, 2'b01, 2'b00, 64'h200, '0, 1'b0, acc);
      #1;
      n_checks++;
      if ({ras_push_o, ras_pop_o, ras_data_o} !== {1'b1, 1'b1, 64'h204})
         $display("FAIL poppush: got push %b pop %b data %h expected 1 1 %h",
                  ras_push_o, ras_pop_o, ras_data_o, 64'h204);
      else n_pass++;
      drain();
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   k       = 0;
      int   guard   = 0;
      bit   checked = 0;
      logic [VLEN-1:0] base;
      while (k < 8 && guard < 40) begin
         base = 64'h1000 + 64'(8 * k);
         if (k == 3 && !checked) begin
            // Three bundles in three cycles with one drain per cycle: 2+2+2-2 = 4.
            fetch_valid_i = 1'b1;
            is_call_i     = 2'b11;
            is_return_i   = 2'b00;
            rvc_i         = 2'b00;
            pc_i[0]       = base;
            pc_i[1]       = base + 64'd4;
            #1;
            n_checks++;
            if (occupancy_o !== 3'd4) $display("FAIL b2b_full_occupancy: got %0d expected 4", occupancy_o); else n_pass++;
            n_checks++;
            if (fetch_ready_o !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", fetch_ready_o); else n_pass++;
            checked = 1;
         end
         drive_cycle(1'b1, 2'b11, 2'b00, 2'b00, base, base + 64'd4, 1'b0, acc);
         if (acc) k++;
         guard++;
      end
      if (k < 8) begin
         n_checks++;
         $display("FAIL b2b_timeout: accepted %0d of 8 bundles", k);
      end
      drain();
   endtask

   task automatic test_flush();
      logic acc;
      drive_cycle(1'b1, 2'b11, 2'b00, 2'b00, 64'h3000, 64'h3004, 1'b0, acc);
      drive_cycle(1'b1, 2'b11, 2'b00, 2'b00, 64'h3008, 64'h300c, 1'b0, acc);
      // Three events now queued; flush while also offering a bundle.
      drive_cycle(1'b1, 2'b01, 2'b00, 2'b00, 64'h3010, '0, 1'b1, acc);
      flush_i       = 1'b0;
      fetch_valid_i = 1'b0;
      is_call_i     = '0;
      #1;
      n_checks++;
      if (occupancy_o !== 3'd0) $display("FAIL flush_after_occupancy: got %0d expected 0", occupancy_o); else n_pass++;
      n_checks++;
      if (ras_push_o !== 1'b0) $display("FAIL flush_after_push: got %b expected 0", ras_push_o); else n_pass++;
      @(negedge clk_i);
      drive_cycle(1'b1, 2'b01, 2'b00, 2'b01, 64'h3100, '0, 1'b0, acc);
      drain();
   endtask

   task automatic test_wrap();
      logic acc;
      drive_cycle(1'b1, 2'b01, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0, acc);
      #1;
      n_checks++;
      if ({ras_push_o, ras_data_o} !== {1'b1, 64'h0})
         $display("FAIL wrap4: got push %b data %h expected 1 0", ras_push_o, ras_data_o);
      else n_pass++;
      @(negedge clk_i);
      drive_cycle(1'b1, 2'b11, 2'b00, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, acc);
      drain();
   endtask

   task automatic test_async_reset();
      logic acc;
      drive_cycle(1'b1, 2'b11, 2'b00, 2'b00, 64'h4000, 64'h4004, 1'b0, acc);
      drive_cycle(1'b1, 2'b11, 2'b00, 2'b00, 64'h4008, 64'h400c, 1'b0, acc);
      idle_cycle();
      #1;
      n_checks++;
      if (ras_push_o !== 1'b1) $display("FAIL areset_pre_push: got %b expected 1", ras_push_o); else n_pass++;
      #1;
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if (ras_push_o !== 1'b0) $display("FAIL areset_push: got %b expected 0", ras_push_o); else n_pass++;
      n_checks++;
      if (ras_pop_o !== 1'b0) $display("FAIL areset_pop: got %b expected 0", ras_pop_o); else n_pass++;
      n_checks++;
      if (ras_data_o !== '0) $display("FAIL areset_data: got %h expected 0", ras_data_o); else n_pass++;
      n_checks++;
      if (occupancy_o !== 3'd0) $display("FAIL areset_occupancy: got %0d expected 0", occupancy_o); else n_pass++;
      sb.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      drive_cycle(1'b1, 2'b10, 2'b00, 2'b00, '0, 64'h5000, 1'b0, acc);
      drain();
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_call_return();
      test_poppush();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
